alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage arithmetic unit that consumes the 4-bit `alusel` code produced by the ALU control decoder, together with two operands, and returns a registered result plus condition flags. Every op except shifts completes in one cycle. By default, shifts run iteratively at one bit per cycle. The block uses a valid/ready handshake on both sides, so the pipeline's hazard logic can stall around multi-cycle shifts.

## Interface
- `XLEN`, default 32: operand and result width. Must be a power of two, at least 8.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: a request is present on `alusel`, `op_a`, `op_b`.
- `in_ready`  out  1: the unit accepts the request this cycle.
- `alusel`  in  4: operation code, using the `ALU_*` encodings from `defines.v`.
- `op_a`  in  XLEN: first operand (rs1 value).
- `op_b`  in  XLEN: second operand (rs2 value or immediate).
- `flush`  in  1: synchronous kill of any in-flight or held operation.
- `out_valid`  out  1: `result` and the flags are valid.
- `out_ready`  in  1: the consumer takes the result this cycle.
- `result`  out  XLEN: operation result.
- `zf`, `cf`, `vf`, `sf`  out  1 each: zero, carry, signed overflow and sign flags.
- `busy`  out  1: a shift is in progress (state SHIFT).

## Operation
- **States:**
  - IDLE: no request held; waiting for a new one.
  - SHIFT: a multi-cycle shift is in progress.
  - DONE: a result is held and `out_valid` is 1.
- **Accept:** a request is accepted when `in_valid && in_ready`. `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is 0 while `rst` is high.
- **Non-shift ops:** the result and flags are registered at accept, and the state goes to DONE.
  - ADD: `op_a+op_b`.
  - SUB: `op_a-op_b`.
  - AND, OR, XOR: bitwise.
  - SLT: signed `op_a<op_b`, result 1/0, zero-extended.
  - SLTU: unsigned `op_a<op_b`, result 1/0, zero-extended.
  - PASS, and any undefined code: `result = op_b`.
- **Shift ops (SLL, SRL, SRA):**
  - shamt = `op_b[log2(XLEN)-1:0]`; the upper bits of `op_b` are ignored.
  - shamt==0: go straight to DONE with `result = op_a`.
  - Otherwise: load `op_a` into the work register and shamt into the counter, then enter SHIFT. Each SHIFT cycle shifts 1 bit and decrements the counter.
    - SRA fills with the sign bit; SLL and SRL fill with 0.
    - When the counter reaches 0, the state goes to DONE.
- **ADD/SUB flags:**
  - Computed on an (XLEN+1)-bit sum. SUB is computed as `op_a + ~op_b + 1`.
  - `cf` = bit XLEN of that sum, so for SUB `cf`=1 means `op_a >= op_b` unsigned.
  - `vf` = signed overflow.
  - `zf` = (result==0); `sf` = result MSB.
- **Flags for all other ops:** `cf`=`vf`=0; `zf` and `sf` are derived from the result.
- **DONE:** `out_valid`=1; the result and flags stay stable until `out_ready`.
  - When `out_ready` is high, the state goes to IDLE, or reloads directly if a new request is accepted in the same cycle (back-to-back).
- **Flush:**
  - Has priority over accept, shift progress and output.
  - Next state is IDLE, `out_valid` is 0, and any held result is discarded.
  - A request presented together with `flush` is not accepted.
- **Reset:** state IDLE, `out_valid`=0, `result`=0, all flags 0, `busy`=0, shift counter 0. Reset applies from any state, including mid-shift.

## Timing
- Non-shift ops, and shifts with shamt==0: `out_valid` rises on the edge after accept (latency 1).
- Iterative shifts: latency shamt+1 cycles. The worst case is XLEN cycles (shamt = XLEN-1).
- Throughput: one result per cycle for non-shift ops while `out_ready` is held at 1.
- `in_ready` and `busy` are combinational from state and `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- All outputs other than `in_ready` are registered.

## Configuration
- `ALU_FAST_SHIFT_EN`:
  - Defined: a single-cycle barrel shifter is built. All ops have latency 1, SHIFT is unreachable and `busy` is tied to 0.
  - Undefined: the iterative 1-bit/cycle shifter described above is built.
- Functional results are identical in both builds.

## Test plan
- **ADD overflow:** ADD `op_a`=0x7FFFFFFF, `op_b`=1 -> one cycle later `out_valid`=1, `result`=0x80000000, `vf`=1, `sf`=1, `cf`=0, `zf`=0.
- **SUB equal:** SUB `op_a`=5, `op_b`=5 -> `result`=0, `zf`=1, `cf`=1. Then SUB 3-5 -> `result`=0xFFFFFFFE, `cf`=0, `sf`=1.
- **SRA iterative:** SRA `op_a`=0x80000000, `op_b`=0x24 (shamt 4) -> `busy` high for 4 cycles, `out_valid` on cycle 5, `result`=0xF8000000. With `ALU_FAST_SHIFT_EN`: result on cycle 1.
- **Back-to-back with backpressure:** SLT -1,1 followed by SLTU -1,1, with `out_ready`=0 for 3 cycles -> first `result`=1 held stable; `in_ready`=0 until `out_ready`; then second `result`=0 on the next cycle.
- **Flush and reset mid-shift:** start SLL 1 by 31, assert `flush` on cycle 10 -> IDLE next cycle, no `out_valid`. Repeat with `rst` asserted mid-shift -> all outputs 0 immediately.
- **Undefined code and shamt 0:** undefined `alusel` with `op_b`=0xDEADBEEF -> `result`=0xDEADBEEF. SRL with shamt 0 -> `result`=`op_a` at latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes, registered result/flags and an iterative 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to build a single-cycle barrel shifter instead (SHIFT state becomes unreachable).
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alusel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // ALU control decoder encodings; codes 11..15 are undefined and behave as PASS.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam int MSB = XLEN - 1;
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never depends on valid, and flush suppresses the input transfer.

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zf, r_cf, r_vf, r_sf;
  logic [XLEN-1:0] r_work;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_shk;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_result_nxt;
  logic            w_zf_nxt, w_cf_nxt, w_vf_nxt, w_sf_nxt;
  logic [XLEN-1:0] w_work_nxt;
  logic [SHW-1:0]  w_cnt_nxt;
  logic [1:0]      w_shk_nxt;

  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_sub;
  logic [XLEN-1:0] w_b_eff;
  logic [XLEN:0]   w_sum;
  logic            w_lt_s, w_lt_u;
  logic [XLEN-1:0] w_op_res;
  logic            w_op_cf, w_op_vf, w_op_iter;
  logic [1:0]      w_op_shk;
  logic [XLEN-1:0] w_step;

  assign in_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign vf        = r_vf;
  assign sf        = r_sf;
  assign dbg_state = r_state;
`ifdef ALU_FAST_SHIFT_EN
  assign busy      = 1'b0;
`else
  assign busy      = (r_state == S_SHIFT);
`endif

  // SUB reuses the adder as op_a + ~op_b + 1 so carry means "no borrow".
  assign w_shamt  = op_b[SHW-1:0];
  assign w_is_sub = (alusel == ALU_SUB);
  assign w_b_eff  = w_is_sub ? ~op_b : op_b;
  assign w_sum    = {1'b0, op_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};
  assign w_lt_s   = $signed(op_a) < $signed(op_b);
  assign w_lt_u   = op_a < op_b;

  always_comb begin
    w_op_res  = op_b;
    w_op_cf   = 1'b0;
    w_op_vf   = 1'b0;
    w_op_iter = 1'b0;
    w_op_shk  = SH_SLL;
    case (alusel)
      ALU_ADD, ALU_SUB: begin
        w_op_res = w_sum[MSB:0];
        w_op_cf  = w_sum[XLEN];
        w_op_vf  = (op_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != op_a[MSB]);
      end
      ALU_AND:  w_op_res = op_a & op_b;
      ALU_OR:   w_op_res = op_a | op_b;
      ALU_XOR:  w_op_res = op_a ^ op_b;
      ALU_SLT:  w_op_res = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: w_op_res = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        if (alusel == ALU_SRL)      w_op_shk = SH_SRL;
        else if (alusel == ALU_SRA) w_op_shk = SH_SRA;
        else                        w_op_shk = SH_SLL;
`ifdef ALU_FAST_SHIFT_EN
        case (w_op_shk)
          SH_SRL:  w_op_res = op_a >> w_shamt;
          SH_SRA:  w_op_res = $unsigned($signed(op_a) >>> w_shamt);
          default: w_op_res = op_a << w_shamt;
        endcase
`else
        // A zero shift amount completes immediately with op_a unchanged.
        w_op_res  = op_a;
        w_op_iter = (w_shamt != '0);
`endif
      end
      ALU_PASS: w_op_res = op_b;
      default:  w_op_res = op_b;
    endcase
  end

  always_comb begin
    case (r_shk)
      SH_SRL:  w_step = {1'b0, r_work[MSB:1]};
      SH_SRA:  w_step = {r_work[MSB], r_work[MSB:1]};
      default: w_step = {r_work[MSB-1:0], 1'b0};
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zf_nxt     = r_zf;
    w_cf_nxt     = r_cf;
    w_vf_nxt     = r_vf;
    w_sf_nxt     = r_sf;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_shk_nxt    = r_shk;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_SHIFT: begin
          w_work_nxt = w_step;
          w_cnt_nxt  = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = w_step;
            w_zf_nxt     = (w_step == '0);
            w_sf_nxt     = w_step[MSB];
            w_cf_nxt     = 1'b0;
            w_vf_nxt     = 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
      // Accept overrides the DONE drain so back-to-back requests reload directly.
      if (w_accept) begin
        if (w_op_iter) begin
          w_state_nxt = S_SHIFT;
          w_work_nxt  = op_a;
          w_cnt_nxt   = w_shamt;
          w_shk_nxt   = w_op_shk;
        end else begin
          w_state_nxt  = S_DONE;
          w_result_nxt = w_op_res;
          w_zf_nxt     = (w_op_res == '0);
          w_sf_nxt     = w_op_res[MSB];
          w_cf_nxt     = w_op_cf;
          w_vf_nxt     = w_op_vf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_vf     <= 1'b0;
      r_sf     <= 1'b0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_shk    <= SH_SLL;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zf     <= w_zf_nxt;
      r_cf     <= w_cf_nxt;
      r_vf     <= w_vf_nxt;
      r_sf     <= w_sf_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shk    <= w_shk_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: stimulus pushes expected {result,zf,cf,vf,sf}
// into a queue, and a negedge monitor pops and compares on every output handshake.
module tb_alu_exec_unit;

  localparam int XLEN = 32;
  localparam int PW   = XLEN + 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alusel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zf, cf, vf, sf;
  logic            busy;
  logic [1:0]      dbg_state;

  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alusel    (alusel),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .sf        (sf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pack(input logic [XLEN-1:0] r, input logic z, input logic c,
                                         input logic v, input logic s);
    return {r, z, c, v, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: holds the request until accepted; returns 1 time unit after the accepting edge
  task automatic issue(input logic [3:0] sel, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [PW-1:0] exp, input bit push);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    alusel   = sel;
    op_a     = a;
    op_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        accepted = 1'b1;
        if (push) exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: sel %0d not accepted within 100 cycles", sel);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h with empty expected queue", {result, zf, cf, vf, sf});
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if ({result, zf, cf, vf, sf} !== e) begin
          n_fail++;
          $display("FAIL result_flags: got %h expected %h", {result, zf, cf, vf, sf}, e);
        end
      end
    end
  end

  initial begin
    int cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alusel    = 4'd0;
    op_a      = '0;
    op_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zf, cf, vf, sf}, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    // arithmetic / logic back-to-back
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, pack(32'h8000_0000, 0, 0, 1, 1), 1);
    check("add_latency1", out_valid, 1);
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, pack(32'h0, 1, 1, 0, 0), 1);
    issue(ALU_SUB, 32'd5, 32'd5, pack(32'h0, 1, 1, 0, 0), 1);
    issue(ALU_SUB, 32'd3, 32'd5, pack(32'hFFFF_FFFE, 0, 0, 0, 1), 1);
    issue(ALU_SUB, 32'h8000_0000, 32'h1, pack(32'h7FFF_FFFF, 0, 1, 1, 0), 1);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'hF000_F000, 0, 0, 0, 1), 1);
    issue(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, pack(32'h0F0F_00F0, 0, 0, 0, 0), 1);
    issue(ALU_XOR, 32'hAAAA_5555, 32'hAAAA_5555, pack(32'h0, 1, 0, 0, 0), 1);
    idle(2);

    // shifts
    issue(ALU_SRA, 32'h8000_0000, 32'h24, pack(32'hF800_0000, 0, 0, 0, 1), 1);
`ifdef ALU_FAST_SHIFT_EN
    check("sra_fast_out_valid", out_valid, 1);
    check("sra_fast_busy", busy, 0);
`else
    check("sra_busy_c1", {busy, out_valid}, 2'b10);
    for (int i = 2; i <= 4; i++) begin
      idle(1);
      check("sra_busy_cn", {busy, out_valid}, 2'b10);
    end
    idle(1);
    check("sra_done_c5", {busy, out_valid}, 2'b01);
`endif
    issue(ALU_SLL, 32'h3, 32'h1, pack(32'h6, 0, 0, 0, 0), 1);
    issue(ALU_SRL, 32'h8000_0000, 32'h1F, pack(32'h1, 0, 0, 0, 0), 1);
    idle(40);
    issue(ALU_SRL, 32'h1234_5678, 32'h20, pack(32'h1234_5678, 0, 0, 0, 0), 1);
    check("srl_shamt0_latency1", out_valid, 1);
    issue(4'hF, 32'h1, 32'hDEAD_BEEF, pack(32'hDEAD_BEEF, 0, 0, 0, 1), 1);
    issue(ALU_PASS, 32'h1, 32'h0, pack(32'h0, 1, 0, 0, 0), 1);
    idle(2);

    // back-to-back with backpressure
    out_ready = 1'b0;
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, pack(32'h1, 0, 0, 0, 0), 1);
    in_valid = 1'b1;
    alusel   = ALU_SLTU;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'h1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_held", {out_valid, result}, {1'b1, 32'h1});
      idle(1);
    end
    out_ready = 1'b1;
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, pack(32'h0, 1, 0, 0, 0), 1);
    check("bp_second", {out_valid, result}, {1'b1, 32'h0});
    idle(2);

    // flush mid-shift (or of a held result in the fast build)
    out_ready = 1'b0;
    issue(ALU_SLL, 32'h1, 32'h1F, '0, 0);
    idle(8);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush_state", {out_valid, busy, dbg_state}, 4'b0000);
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (out_valid) cnt++;
    end
    check("flush_no_output", cnt, 0);

    // request together with flush is not accepted
    in_valid = 1'b1;
    alusel   = ALU_ADD;
    op_a     = 32'h1;
    op_b     = 32'h1;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_blocks_accept", {out_valid, dbg_state}, 3'b000);

    // reset mid-shift
    out_ready = 1'b0;
    issue(ALU_SLL, 32'h1, 32'h1F, '0, 0);
    idle(5);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {out_valid, busy, in_ready, zf, cf, vf, sf, result}, '0);
    check("rst_mid_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(ALU_ADD, 32'd2, 32'd3, pack(32'd5, 0, 0, 0, 0), 1);
    check("post_rst_add", {out_valid, result}, {1'b1, 32'd5});

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
